// File: rtl/noc_axi_txn_scheduler.sv
// Front-end scheduler for the NoC-to-AXI bridge: round-robin AR/AW arbitration, per-beat request split, credit-bounded.
// Optional NOC_AXI_DIR_FENCE_EN: direction changes wait for a drained response path and full credits.
module noc_axi_txn_scheduler #(
    parameter int          AXI_DATA_WIDTH  = 64,
    parameter int          AXI_ADDR_WIDTH  = 64,
    parameter int          MAX_OUTSTANDING = 16,
    parameter logic [1:0]  MSG_TYPE_LOAD   = 2'd1,
    parameter logic [1:0]  MSG_TYPE_STORE  = 2'd2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ar_valid,
    output logic                      ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]                ar_len,
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    input  logic [7:0]                aw_len,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic                      req_is_store,
    output logic [AXI_ADDR_WIDTH-1:0] req_addr,
    output logic                      transaction_type_wr,
    output logic [5:0]                transaction_type_wr_data,
    input  logic                      beat_done,
    input  logic                      previous_trans_complete,
    output logic                      busy
);

    localparam int                        CW          = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0]             CREDIT_FULL = CW'(MAX_OUTSTANDING);
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES  = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);
    localparam logic                      WIDE        = (AXI_DATA_WIDTH == 128);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        WR_ISSUE
    } state_t;

    state_t                    state, state_nxt;
    logic [CW-1:0]             credits;
    logic                      rr_last_wr;
    logic [7:0]                beat_cnt;
    logic [7:0]                beat_len;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic                      store_q;
    logic [5:0]                desc_q;

    logic                      pick_rd, pick_wr, fence_open;
    logic                      grant_rd, grant_wr, grant;
    logic                      issue, last_beat, credit_ret;
    logic [AXI_ADDR_WIDTH-1:0] addr_next;
    logic [AXI_ADDR_WIDTH-1:0] grant_addr;
    logic [7:0]                grant_len;

    function automatic logic [5:0] make_desc(input logic st, input logic a3, input logic last);
        return {st & last, ~st & last, WIDE, WIDE ? 1'b0 : a3,
                st ? MSG_TYPE_STORE : MSG_TYPE_LOAD};
    endfunction

    // rr_last_wr doubles as the direction of the previous burst once one has been granted
`ifdef NOC_AXI_DIR_FENCE_EN
    logic prev_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_vld <= 1'b0;
        end else if (grant) begin
            prev_vld <= 1'b1;
        end
    end

    assign fence_open = !prev_vld || (pick_wr == rr_last_wr) ||
                        (previous_trans_complete && (credits == CREDIT_FULL));
`else
    logic unused_prev_trans_complete;
    assign unused_prev_trans_complete = previous_trans_complete;
    assign fence_open = 1'b1;
`endif

    assign pick_rd    = ar_valid && (!aw_valid || rr_last_wr);
    assign pick_wr    = aw_valid && !pick_rd;
    assign grant_rd   = (state == IDLE) && pick_rd && fence_open;
    assign grant_wr   = (state == IDLE) && pick_wr && fence_open;
    assign grant      = grant_rd || grant_wr;
    assign grant_addr = grant_wr ? aw_addr : ar_addr;
    assign grant_len  = grant_wr ? aw_len : ar_len;
    assign addr_next  = addr_q + BEAT_BYTES;
    assign last_beat  = (beat_cnt == beat_len);
    assign issue      = req_valid && req_ready;
    assign credit_ret = beat_done && (credits != CREDIT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_rd) begin
                    state_nxt = RD_ISSUE;
                end else if (grant_wr) begin
                    state_nxt = WR_ISSUE;
                end
            end
            RD_ISSUE, WR_ISSUE: begin
                if (issue && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ar_ready                 = grant_rd;
        aw_ready                 = grant_wr;
        req_valid                = (state != IDLE) && (credits != '0);
        transaction_type_wr      = (state != IDLE) && (credits != '0) && req_ready;
        req_addr                 = addr_q;
        req_is_store             = store_q;
        transaction_type_wr_data = desc_q;
        busy                     = (state != IDLE) || (credits != CREDIT_FULL);
    end

    // Descriptor is precomputed for the beat being presented so it is stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            store_q  <= 1'b0;
            beat_cnt <= '0;
            beat_len <= '0;
            desc_q   <= '0;
        end else if (grant) begin
            addr_q   <= grant_addr;
            store_q  <= grant_wr;
            beat_cnt <= '0;
            beat_len <= grant_len;
            desc_q   <= make_desc(grant_wr, grant_addr[3], grant_len == 8'd0);
        end else if (issue) begin
            addr_q   <= addr_next;
            beat_cnt <= beat_cnt + 8'd1;
            desc_q   <= make_desc(store_q, addr_next[3], (beat_cnt + 8'd1) == beat_len);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_wr <= 1'b1;
        end else if (grant) begin
            rr_last_wr <= grant_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CREDIT_FULL;
        end else begin
            case ({issue, credit_ret})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_axi_txn_scheduler.sv
// Scoreboard bench for noc_axi_txn_scheduler: a transaction-level model predicts grants, beats and credits.
module tb_noc_axi_txn_scheduler;

    localparam int MAX = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ar_valid = 1'b0, aw_valid = 1'b0;
    logic        ar_ready, aw_ready;
    logic [63:0] ar_addr = '0, aw_addr = '0;
    logic [7:0]  ar_len = '0, aw_len = '0;
    logic        req_valid, req_is_store, transaction_type_wr, busy;
    logic        req_ready = 1'b0;
    logic [63:0] req_addr;
    logic [5:0]  transaction_type_wr_data;
    logic        beat_done;
    logic        previous_trans_complete = 1'b1;

    logic bd_auto_q = 1'b0, bd_man = 1'b0;
    bit   bd_auto = 0, ready_rand = 0, ready_fixed = 0, ptc_rand = 0;
    assign beat_done = bd_auto_q | bd_man;

    typedef struct {
        logic [63:0] addr;
        logic        st;
        logic [5:0]  desc;
        bit          last;
    } beat_t;

    beat_t exp_q[$];
    int    m_credits = MAX;
    bit    m_active = 0, m_rr_wr = 1, m_prev_vld = 0;
    int    issue_cnt = 0;
    int    n_checks = 0, n_fail = 0;

    noc_axi_txn_scheduler #(
        .AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(64), .MAX_OUTSTANDING(MAX),
        .MSG_TYPE_LOAD(2'd1), .MSG_TYPE_STORE(2'd2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store), .req_addr(req_addr),
        .transaction_type_wr(transaction_type_wr), .transaction_type_wr_data(transaction_type_wr_data),
        .beat_done(beat_done), .previous_trans_complete(previous_trans_complete), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat descriptor straight from the field definitions for a 64-bit data path
    function automatic logic [5:0] exp_desc(input bit st, input logic [63:0] a, input bit last);
        logic [1:0] ft;
        ft = st ? 2'd2 : 2'd1;
        return {st && last, !st && last, 1'b0, a[3], ft};
    endfunction

    function automatic bit fence_ok(input bit wr);
`ifdef NOC_AXI_DIR_FENCE_EN
        return !m_prev_vld || (wr == m_rr_wr) || (previous_trans_complete && m_credits == MAX);
`else
        return wr || 1'b1;
`endif
    endfunction

    always @(negedge clk) begin
        bit    iss, last, e_rd, e_wr, p_rd, p_wr, bd_eff;
        beat_t b;
        if (!rst_n) begin
            check("rst_req_valid", req_valid, 0);
            check("rst_req_addr", req_addr, 0);
            check("rst_req_is_store", req_is_store, 0);
            check("rst_type_wr", transaction_type_wr, 0);
            check("rst_type_data", transaction_type_wr_data, 0);
            check("rst_ar_ready", ar_ready, 0);
            check("rst_aw_ready", aw_ready, 0);
            check("rst_busy", busy, 0);
            exp_q.delete();
            m_credits = MAX; m_active = 0; m_rr_wr = 1; m_prev_vld = 0;
        end else begin
            iss  = req_valid && req_ready;
            last = 0;
            check("busy", busy, m_active || m_credits != MAX);
            check("req_valid", req_valid, m_active && m_credits != 0);
            check("type_wr_strobe", transaction_type_wr, iss);
            if (iss) begin
                issue_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("req_addr", req_addr, b.addr);
                    check("req_is_store", req_is_store, b.st);
                    check("descriptor", transaction_type_wr_data, b.desc);
                    last = b.last;
                end
            end
            if (!m_active) begin
                p_rd = ar_valid && (!aw_valid || m_rr_wr);
                p_wr = aw_valid && !p_rd;
                e_rd = p_rd && fence_ok(0);
                e_wr = p_wr && fence_ok(1);
                check("ar_ready", ar_ready, e_rd);
                check("aw_ready", aw_ready, e_wr);
                if (e_rd || e_wr) begin
                    logic [63:0] a0;
                    int          n;
                    a0 = e_wr ? aw_addr : ar_addr;
                    n  = e_wr ? int'(aw_len) : int'(ar_len);
                    for (int i = 0; i <= n; i++) begin
                        b.addr = a0 + 64'(i) * 64'd8;
                        b.st   = e_wr;
                        b.last = (i == n);
                        b.desc = exp_desc(e_wr, b.addr, b.last);
                        exp_q.push_back(b);
                    end
                    m_active = 1; m_rr_wr = e_wr; m_prev_vld = 1;
                end
            end else begin
                check("ready_while_busy", {ar_ready, aw_ready}, 0);
            end
            bd_eff = beat_done && (m_credits != MAX);
            if (iss && !bd_eff) m_credits--;
            else if (!iss && bd_eff) m_credits++;
            if (last) m_active = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        req_ready = ready_rand ? ($urandom % 4 != 0) : ready_fixed;
        bd_auto_q = bd_auto && (m_credits < MAX) && ($urandom % 3 == 0);
        previous_trans_complete = ptc_rand ? ($urandom % 2 == 0) : 1'b1;
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_burst(input bit wr, input logic [63:0] a, input logic [7:0] l);
        bit done = 0;
        int n = 0;
        if (wr) begin aw_valid = 1; aw_addr = a; aw_len = l; end
        else    begin ar_valid = 1; ar_addr = a; ar_len = l; end
        while (!done) begin
            @(negedge clk);
            done = wr ? aw_ready : ar_ready;
            @(posedge clk); #1;
            n++;
            if (!done && n > 3000) begin
                check(wr ? "aw_grant_timeout" : "ar_grant_timeout", 0, 1);
                done = 1;
            end
        end
        if (wr) aw_valid = 0; else ar_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        bd_auto = 1;
        while ((exp_q.size() != 0 || m_active || m_credits != MAX) && n < 5000) begin
            cycles(1); n++;
        end
        check("drain_timeout", n < 5000, 1);
        cycles(2);
    endtask

    task automatic pulse_bd(input int n);
        bd_man = 1; cycles(n); bd_man = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        int          n;
        cycles(3);
        rst_n = 1;

        // contention straight out of reset, then repeated
        bd_auto = 1; ready_rand = 1;
        for (int k = 0; k < 3; k++) begin
            fork
                do_burst(0, 64'h100 + 64'(k) * 64'h40, 8'd1);
                do_burst(1, 64'h800 + 64'(k) * 64'h40, 8'd2);
            join
        end
        wait_idle();

        // single read, busy held until its credit returns
        bd_auto = 0; ready_rand = 0; ready_fixed = 1;
        do_burst(0, 64'h1008, 8'd0);
        cycles(3);
        check("busy_before_beat_done", busy, 1);
        pulse_bd(1);
        cycles(1);
        check("busy_after_beat_done", busy, 0);

        // 4-beat write, back to back
        do_burst(1, 64'h2000, 8'd3);
        wait_idle();

        // credit starvation
        bd_auto = 0; issue_cnt = 0;
        do_burst(0, 64'h3000, 8'd19);
        n = 0;
        while (m_credits != 0 && n < 200) begin cycles(1); n++; end
        cycles(4);
        check("starve_issue_count", issue_cnt, 16);
        pulse_bd(1); cycles(3);
        check("one_credit_one_beat", issue_cnt, 17);
        pulse_bd(2); cycles(4);
        check("coincident_credit", issue_cnt, 19);
        wait_idle();
        check("starve_total", issue_cnt, 20);

        // reset in the middle of a burst
        bd_auto = 0; issue_cnt = 0;
        do_burst(0, 64'h4000, 8'd3);
        n = 0;
        while (issue_cnt < 2 && n < 100) begin cycles(1); n++; end
        rst_n = 0;
        #1;
        check("midrst_req_valid", req_valid, 0);
        check("midrst_busy", busy, 0);
        cycles(2);
        rst_n = 1;
        cycles(1);
        do_burst(0, 64'h5008, 8'd1);
        wait_idle();

        // randomized traffic
        ready_rand = 1; ptc_rand = 1; bd_auto = 1;
        for (int k = 0; k < 40; k++) begin
            a = {$urandom(), $urandom()};
            a[2:0] = 3'b000;
            case ($urandom % 3)
                0: do_burst(0, a, 8'($urandom_range(0, 7)));
                1: do_burst(1, a, 8'($urandom_range(0, 7)));
                default: fork
                    do_burst(0, a, 8'($urandom_range(0, 5)));
                    do_burst(1, a ^ 64'h1000, 8'($urandom_range(0, 5)));
                join
            endcase
            cycles($urandom_range(0, 3));
        end
        ptc_rand = 0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
